core_clock_ctrl: RTL and testbench
==================================

// Module: core_clock_ctrl
// PURPOSE
// - Run/step controller directly upstream of the CPU core clock. Replaces the free-running clock
//   path with a single-cycle clock enable (core_clk_en) derived from board_clk.
// - Modes: manual single-step, auto-run via programmable prescaler, burst of N ticks, and
//   PC breakpoint; a core halt stops all modes.
// - Control inputs come from the probe-bus mapping; status goes back out on probe outputs.
// PARAMETERS
// - DIV_W   27  prescaler width; auto/burst tick period = run_div board clocks
// - PC_W    8   width of pc / bp_addr
// - CNT_W   16  width of burst count
// - TICK_W  32  width of tick counter
// PORTS
// - clk            in   1       board clock, 100 MHz
// - rst            in   1       synchronous reset, active-high
// - auto_en        in   1       level; auto-run request, asynchronous to clk
// - step           in   1       level; one tick per rising edge, asynchronous to clk
// - run_n_start    in   1       level; burst start on rising edge, asynchronous to clk
// - run_n_count    in   CNT_W   burst length, sampled at burst start
// - run_div        in   DIV_W   tick period in clk cycles; 0 is treated as 1
// - bp_en          in   1       breakpoint enable
// - bp_addr        in   PC_W    breakpoint address
// - pc             in   PC_W    current core PC
// - core_halted    in   1       core executed HLT
// - core_clk_en    out  1       one-clk pulse = one core tick
// - state          out  2       0 IDLE, 1 AUTO, 2 BURST, 3 BREAK
// - break_hit      out  1       high while in BREAK
// - burst_left     out  CNT_W   remaining burst ticks
// - tick_cnt       out  TICK_W  ticks issued since reset; wraps
// BEHAVIOUR
// - Reset: state=IDLE; core_clk_en, break_hit, burst_left, tick_cnt and prescaler = 0.
// - Synchroniser and edge-history flops for auto_en, step and run_n_start reset to 1.
//   An input held high through reset therefore gives no edge; a new edge needs a low first.
// - Each async input passes a 2-flop synchroniser; rising-edge detect uses one more flop.
//   A step edge makes core_clk_en high for exactly 1 cycle, 3 cycles after the first clk
//   edge that samples step=1.
// - core_clk_en is never high on two consecutive cycles, except in BURST/AUTO with run_div<=1.
// - core_halted=1 blocks all pulses, including step; AUTO and BURST go to IDLE.
// - IDLE: sync auto_en=1 -> AUTO. Else run_n_start edge with run_n_count!=0 -> BURST,
//   burst_left=run_n_count. Else step edge -> one pulse. Priority: AUTO > BURST > step.
//   run_n_count=0 at start: ignored.
// - Prescaler: counts 0..max(run_div,1)-1 in AUTO/BURST. Pulse on the terminal count, then
//   wrap to 0. Cleared on every state change. A run_div change takes effect at the next wrap.
// - AUTO: sync auto_en=0 -> IDLE with no further pulse.
// - BURST: each pulse decrements burst_left; the pulse that brings it to 0 also returns to
//   IDLE. auto_en rising during BURST -> AUTO, burst_left cleared. step is ignored.
// - Breakpoint (AUTO/BURST): on a terminal-count cycle, if bp_en and pc==bp_addr, the pulse is
//   suppressed and state -> BREAK. The first terminal count after entering AUTO/BURST is exempt
//   from this check, so a resume off the breakpoint PC is possible.
// - BREAK: no pulses from the prescaler. A step edge gives one pulse and stays in BREAK.
//   sync auto_en=0 -> IDLE; burst_left is cleared.
// - tick_cnt increments on every core_clk_en pulse; wraps 2^TICK_W-1 -> 0.
// - rst during any mode: back to IDLE within the same cycle, with no pulse.
// STRUCTURE
// - Package core_clock_pkg: state enum (IDLE/AUTO/BURST/BREAK, 2 bits), default widths.
// - Sub-module sync_edge_detect: 2-flop synchroniser plus rising-edge flop, reset value 1,
//   instantiated 3 times.
// - Top level: state FSM, prescaler, burst counter, tick counter. All logic on clk;
//   core_clk_en is registered.
// TESTING
// - Step held high through reset, released, then pulsed 3x -> exactly 3 single-cycle pulses,
//   each 3 cycles after its edge; tick_cnt=3.
// - auto_en=1, run_div=4 -> state=1, pulses every 4th cycle. run_div=0 -> pulse every cycle.
//   auto_en=0 -> IDLE, no further pulse.
// - run_n_count=5, run_div=2, start edge -> exactly 5 pulses 2 cycles apart; burst_left 5->0;
//   then IDLE. run_n_count=0 -> no pulses.
// - bp_en=1, bp_addr=8'h07, pc model increments per tick from 0, AUTO -> 7 pulses, then
//   BREAK. A step edge -> one pulse. auto_en=0 -> IDLE.
// - Resume with pc==bp_addr and AUTO -> first pulse issued; later match -> BREAK.
// - core_halted=1 mid-AUTO -> IDLE, steps give no pulses. rst mid-BURST -> all outputs 0 next cycle.

Source files
------------

// File: rtl/core_clock_ctrl_pkg.sv
// Shared types and default widths for the core clock run/step controller.
package core_clock_pkg;

    localparam int unsigned DefDivW  = 27;
    localparam int unsigned DefPcW   = 8;
    localparam int unsigned DefCntW  = 16;
    localparam int unsigned DefTickW = 32;

    // Encoding is visible on the probe bus: 0 IDLE, 1 AUTO, 2 BURST, 3 BREAK.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAuto  = 2'd1,
        StBurst = 2'd2,
        StBreak = 2'd3
    } core_state_e;

endpackage

// File: rtl/core_clock_ctrl_if.sv
// Probe-bus control/status bundle between the debug probe and the clock controller.
interface core_clock_ctrl_if #(
    parameter int unsigned DIV_W  = core_clock_pkg::DefDivW,
    parameter int unsigned PC_W   = core_clock_pkg::DefPcW,
    parameter int unsigned CNT_W  = core_clock_pkg::DefCntW,
    parameter int unsigned TICK_W = core_clock_pkg::DefTickW
);

    logic              auto_en;
    logic              step;
    logic              run_n_start;
    logic [CNT_W-1:0]  run_n_count;
    logic [DIV_W-1:0]  run_div;
    logic              bp_en;
    logic [PC_W-1:0]   bp_addr;
    logic [PC_W-1:0]   pc;
    logic              core_halted;

    logic              core_clk_en;
    logic [1:0]        state;
    logic              break_hit;
    logic [CNT_W-1:0]  burst_left;
    logic [TICK_W-1:0] tick_cnt;

    // Probe side: drives controls, observes status.
    modport master (
        output auto_en, step, run_n_start, run_n_count, run_div, bp_en, bp_addr, pc,
               core_halted,
        input  core_clk_en, state, break_hit, burst_left, tick_cnt
    );

    // Controller side.
    modport slave (
        input  auto_en, step, run_n_start, run_n_count, run_div, bp_en, bp_addr, pc,
               core_halted,
        output core_clk_en, state, break_hit, burst_left, tick_cnt
    );

endinterface

// File: rtl/core_clock_ctrl_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level plus a registered rising-edge pulse.
// All history flops reset to 1 so an input held high through reset produces no edge.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;
    logic rise_q;

    // Synchronise, keep one cycle of history and register the rising-edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            rise_q  <= sync2_q & ~hist_q;
        end
    end

    assign level = sync2_q;
    assign rise  = rise_q;

endmodule

// File: rtl/core_clock_ctrl.sv
// Run/step controller producing a single-cycle core clock enable from the board clock.
// Modes: manual step, auto-run on a prescaler, burst of N ticks, PC breakpoint; a core
// halt stops everything.
module core_clock_ctrl
    import core_clock_pkg::*;
#(
    parameter int unsigned DIV_W  = DefDivW,
    parameter int unsigned CNT_W  = DefCntW,
    parameter int unsigned TICK_W = DefTickW
) (
    input logic              clk,
    input logic              rst,
    core_clock_ctrl_if.slave bus
);

    logic auto_lvl;
    logic auto_rise;
    logic step_lvl;
    logic step_rise;
    logic start_lvl;
    logic start_rise;

    sync_edge_detect u_sync_auto (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.auto_en),
        .level    (auto_lvl),
        .rise     (auto_rise)
    );

    sync_edge_detect u_sync_step (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.step),
        .level    (step_lvl),
        .rise     (step_rise)
    );

    sync_edge_detect u_sync_start (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.run_n_start),
        .level    (start_lvl),
        .rise     (start_rise)
    );

    // Only the edges of step and run_n_start matter.
    logic unused_lvl;
    assign unused_lvl = step_lvl ^ start_lvl;

    core_state_e       state_q;
    logic [DIV_W-1:0]  presc_q;
    logic [DIV_W-1:0]  div_q;
    logic              first_q;
    logic [CNT_W-1:0]  burst_left_q;
    logic [TICK_W-1:0] tick_q;
    logic              clk_en_q;

    logic [DIV_W-1:0]  eff_div;
    logic              tc;
    logic              bp_match;

    // run_div=0 behaves as 1; the divider is latched so a change lands on the next wrap.
    assign eff_div  = (bus.run_div == '0) ? DIV_W'(1) : bus.run_div;
    assign tc       = (presc_q == div_q - DIV_W'(1));
    // The first terminal count after entering a run mode skips the check to allow resume.
    assign bp_match = bus.bp_en && (bus.pc == bus.bp_addr) && !first_q;

    // State FSM, prescaler, burst and tick counters with a registered clock enable.
    // Note: the auto_en synchroniser reads high for two cycles after reset, so the FSM may
    // pass briefly through AUTO; no tick is issued unless the divider wraps in that window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            div_q        <= DIV_W'(1);
            first_q      <= 1'b0;
            burst_left_q <= '0;
            tick_q       <= '0;
            clk_en_q     <= 1'b0;
        end else begin
            clk_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!bus.core_halted) begin
                        if (auto_lvl) begin
                            state_q <= StAuto;
                            presc_q <= '0;
                            div_q   <= eff_div;
                            first_q <= 1'b1;
                        end else if (start_rise && (bus.run_n_count != '0)) begin
                            state_q      <= StBurst;
                            burst_left_q <= bus.run_n_count;
                            presc_q      <= '0;
                            div_q        <= eff_div;
                            first_q      <= 1'b1;
                        end else if (step_rise) begin
                            clk_en_q <= 1'b1;
                            tick_q   <= tick_q + TICK_W'(1);
                        end
                    end
                end
                StAuto: begin
                    if (bus.core_halted || !auto_lvl) begin
                        state_q <= StIdle;
                        presc_q <= '0;
                    end else if (tc) begin
                        presc_q <= '0;
                        div_q   <= eff_div;
                        first_q <= 1'b0;
                        if (bp_match) begin
                            state_q <= StBreak;
                        end else begin
                            clk_en_q <= 1'b1;
                            tick_q   <= tick_q + TICK_W'(1);
                        end
                    end else begin
                        presc_q <= presc_q + DIV_W'(1);
                    end
                end
                StBurst: begin
                    if (bus.core_halted) begin
                        state_q      <= StIdle;
                        presc_q      <= '0;
                        burst_left_q <= '0;
                    end else if (auto_rise) begin
                        state_q      <= StAuto;
                        presc_q      <= '0;
                        div_q        <= eff_div;
                        first_q      <= 1'b1;
                        burst_left_q <= '0;
                    end else if (tc) begin
                        presc_q <= '0;
                        div_q   <= eff_div;
                        first_q <= 1'b0;
                        if (bp_match) begin
                            state_q <= StBreak;
                        end else begin
                            clk_en_q     <= 1'b1;
                            tick_q       <= tick_q + TICK_W'(1);
                            burst_left_q <= burst_left_q - CNT_W'(1);
                            if (burst_left_q == CNT_W'(1)) begin
                                state_q <= StIdle;
                            end
                        end
                    end else begin
                        presc_q <= presc_q + DIV_W'(1);
                    end
                end
                StBreak: begin
                    if (!auto_lvl) begin
                        state_q      <= StIdle;
                        presc_q      <= '0;
                        burst_left_q <= '0;
                    end else if (step_rise && !bus.core_halted) begin
                        clk_en_q <= 1'b1;
                        tick_q   <= tick_q + TICK_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.core_clk_en = clk_en_q;
    assign bus.state       = state_q;
    assign bus.break_hit   = (state_q == StBreak);
    assign bus.burst_left  = burst_left_q;
    assign bus.tick_cnt    = tick_q;

endmodule

// File: tb/tb_core_clock_ctrl.sv
// Directed bench for core_clock_ctrl: the driver pushes expected pulse cycles and tick
// counts into a scoreboard; a monitor pops and compares on every core_clk_en pulse.
module tb_core_clock_ctrl;
    import core_clock_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_clock_ctrl_if ifc ();

    core_clock_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct {
        int cyc;
        int tick;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   exp_tick = 0;
    int   pulse_cnt = 0;
    int   pc_base = 0;
    logic pc_auto = 1'b0;
    logic [7:0] pc_force = 8'd0;

    // Edge counter: at a negedge, cyc equals the number of posedges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // PC model: advances by one per core tick while enabled.
    always @(negedge clk) if (ifc.core_clk_en === 1'b1) pulse_cnt <= pulse_cnt + 1;
    assign ifc.pc = pc_auto ? 8'(pulse_cnt - pc_base) : pc_force;

    task automatic push(input int at);
        exp_t e;
        exp_tick = exp_tick + 1;
        e.cyc  = at;
        e.tick = exp_tick;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, act, want, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL pulse_missing got=none want=pulse at cyc %0d", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (ifc.core_clk_en === 1'b1) begin
            total++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                if (ifc.tick_cnt !== 32'(e.tick)) begin
                    bad++;
                    $display("FAIL pulse_tick got=%0d want=%0d (cyc %0d)",
                             ifc.tick_cnt, e.tick, cyc);
                end
            end else begin
                bad++;
                $display("FAIL pulse_unexpected got=pulse want=none at cyc %0d", cyc);
            end
        end
    end

    initial begin
        int c;
        int s;
        ifc.auto_en     = 1'b0;
        ifc.step        = 1'b1;
        ifc.run_n_start = 1'b0;
        ifc.run_n_count = '0;
        ifc.run_div     = 27'd4;
        ifc.bp_en       = 1'b0;
        ifc.bp_addr     = 8'd0;
        ifc.core_halted = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", ifc.state, StIdle);
        check("rst_clk_en", ifc.core_clk_en, 0);
        check("rst_break_hit", ifc.break_hit, 0);
        check("rst_burst_left", ifc.burst_left, 0);
        check("rst_tick_cnt", ifc.tick_cnt, 0);
        rst = 1'b0;

        // Step held through reset gives no edge; then three clean steps.
        repeat (6) @(negedge clk);
        check("step_held_no_tick", ifc.tick_cnt, 0);
        ifc.step = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            c = cyc;
            ifc.step = 1'b1;
            push(c + 4);
            repeat (2) @(negedge clk);
            ifc.step = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("step_tick_cnt", ifc.tick_cnt, 3);
        check("step_state", ifc.state, StIdle);

        // AUTO at run_div=4, then run_div=0 (every cycle), then stop.
        c = cyc;
        ifc.run_div = 27'd4;
        ifc.auto_en = 1'b1;
        push(c + 7);
        push(c + 11);
        push(c + 15);
        wait_until(c + 10);
        check("auto_state", ifc.state, StAuto);
        wait_until(c + 12);
        ifc.run_div = 27'd0;
        for (int k = 16; k <= 20; k++) push(c + k);
        wait_until(c + 18);
        ifc.auto_en = 1'b0;
        wait_until(c + 24);
        check("auto_off_state", ifc.state, StIdle);
        check("auto_tick_cnt", ifc.tick_cnt, 32'(exp_tick));

        // BURST of 5 at run_div=2.
        c = cyc;
        ifc.run_div     = 27'd2;
        ifc.run_n_count = 16'd5;
        ifc.run_n_start = 1'b1;
        for (int k = 0; k < 5; k++) push(c + 6 + 2 * k);
        wait_until(c + 2);
        ifc.run_n_start = 1'b0;
        wait_until(c + 4);
        check("burst_state", ifc.state, StBurst);
        check("burst_left_start", ifc.burst_left, 5);
        wait_until(c + 7);
        check("burst_left_after1", ifc.burst_left, 4);
        wait_until(c + 16);
        check("burst_done_state", ifc.state, StIdle);
        check("burst_done_left", ifc.burst_left, 0);

        // Zero-length burst is ignored.
        c = cyc;
        ifc.run_n_count = 16'd0;
        ifc.run_n_start = 1'b1;
        repeat (2) @(negedge clk);
        ifc.run_n_start = 1'b0;
        wait_until(c + 10);
        check("burst0_state", ifc.state, StIdle);
        check("burst0_tick_cnt", ifc.tick_cnt, 32'(exp_tick));

        // Breakpoint at PC 7 with the PC model advancing per tick.
        ifc.bp_en   = 1'b1;
        ifc.bp_addr = 8'h07;
        ifc.run_div = 27'd3;
        pc_base     = pulse_cnt;
        pc_auto     = 1'b1;
        c = cyc;
        ifc.auto_en = 1'b1;
        for (int k = 0; k < 7; k++) push(c + 6 + 3 * k);
        wait_until(c + 29);
        check("bp_state", ifc.state, StBreak);
        check("bp_break_hit", ifc.break_hit, 1);
        check("bp_pc", ifc.pc, 7);
        s = cyc;
        ifc.step = 1'b1;
        push(s + 4);
        repeat (2) @(negedge clk);
        ifc.step = 1'b0;
        wait_until(s + 7);
        check("bp_step_state", ifc.state, StBreak);
        check("bp_step_tick_cnt", ifc.tick_cnt, 32'(exp_tick));
        c = cyc;
        ifc.auto_en = 1'b0;
        wait_until(c + 5);
        check("bp_exit_state", ifc.state, StIdle);
        check("bp_exit_break_hit", ifc.break_hit, 0);

        // Resume while sitting on the breakpoint PC: first tick exempt, next one breaks.
        pc_auto  = 1'b0;
        pc_force = 8'h07;
        c = cyc;
        ifc.auto_en = 1'b1;
        push(c + 6);
        wait_until(c + 11);
        check("resume_state", ifc.state, StBreak);
        check("resume_break_hit", ifc.break_hit, 1);
        ifc.auto_en = 1'b0;
        repeat (6) @(negedge clk);
        check("resume_exit_state", ifc.state, StIdle);
        ifc.bp_en = 1'b0;

        // Core halt mid-AUTO: back to IDLE, steps blocked.
        c = cyc;
        ifc.run_div = 27'd2;
        ifc.auto_en = 1'b1;
        push(c + 5);
        push(c + 7);
        push(c + 9);
        wait_until(c + 10);
        ifc.core_halted = 1'b1;
        wait_until(c + 12);
        check("halt_state", ifc.state, StIdle);
        ifc.step = 1'b1;
        repeat (2) @(negedge clk);
        ifc.step = 1'b0;
        repeat (6) @(negedge clk);
        check("halt_step_state", ifc.state, StIdle);
        check("halt_step_tick_cnt", ifc.tick_cnt, 32'(exp_tick));
        ifc.auto_en = 1'b0;
        repeat (5) @(negedge clk);
        ifc.core_halted = 1'b0;
        repeat (5) @(negedge clk);
        check("unhalt_state", ifc.state, StIdle);

        // Reset in the middle of a burst.
        c = cyc;
        ifc.run_div     = 27'd2;
        ifc.run_n_count = 16'd10;
        ifc.run_n_start = 1'b1;
        push(c + 6);
        push(c + 8);
        push(c + 10);
        wait_until(c + 2);
        ifc.run_n_start = 1'b0;
        wait_until(c + 7);
        check("rstb_state", ifc.state, StBurst);
        wait_until(c + 11);
        rst = 1'b1;
        wait_until(c + 12);
        exp_tick = 0;
        check("rstb_clk_en", ifc.core_clk_en, 0);
        check("rstb_state_idle", ifc.state, StIdle);
        check("rstb_burst_left", ifc.burst_left, 0);
        check("rstb_tick_cnt", ifc.tick_cnt, 0);
        check("rstb_break_hit", ifc.break_hit, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_state", ifc.state, StIdle);
        check("post_rst_tick_cnt", ifc.tick_cnt, 0);
        check("queue_drained", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
